// File: rtl/lighthouse_pkg.sv
// rtl/lighthouse_pkg.sv - state encoding, sync-code bit fields and clock-scaled timing thresholds
package lighthouse_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_LOW,
    ST_WAIT_RISE,
    ST_MEASURE,
    ST_CLASSIFY
  } state_t;

  localparam int CODE_SKIP = 2;
  localparam int CODE_DATA = 1;
  localparam int CODE_AXIS = 0;

  // 62.5 us
  function automatic int sync_base(input longint clk_hz);
    return int'(clk_hz * 625 / 10_000_000);
  endfunction

  // 10.42 us
  function automatic int sync_step(input longint clk_hz);
    return int'(clk_hz * 1042 / 100_000_000);
  endfunction

  // half a step, centres each code bin on its nominal width
  function automatic int sync_half(input longint clk_hz);
    return int'(clk_hz * 52 / 10_000_000);
  endfunction

  // 30 us
  function automatic int sweep_max(input longint clk_hz);
    return int'(clk_hz * 30 / 1_000_000);
  endfunction

  // 1000 us between the two syncs of a group
  function automatic int lh_gap(input longint clk_hz);
    return int'(clk_hz / 1000);
  endfunction

  // 8.333 ms rotor period, rounded
  function automatic int sweep_window(input longint clk_hz);
    return int'((clk_hz + 60) / 120);
  endfunction

endpackage

// File: rtl/lighthouse_edge_sync.sv
// rtl/lighthouse_edge_sync.sv - 2-flop synchronizer with registered rise/fall strobes
module lighthouse_edge_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta, r_sync, r_prev, r_rise, r_fall;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
      r_prev <= r_sync;
      r_rise <= r_sync & ~r_prev;
      r_fall <= ~r_sync & r_prev;
    end
  end

  // r_prev lines up with the registered edge strobes
  assign o_level = r_prev;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/lighthouse_pulse_decoder.sv
// rtl/lighthouse_pulse_decoder.sv - Lighthouse v1 sync/sweep classifier; DECODER_GLITCH_FILTER_EN drops short glitches
module lighthouse_pulse_decoder
  import lighthouse_pkg::*;
#(
  parameter longint CLK_SPEED     = 50_000_000,
  parameter int     COUNTER_WIDTH = 20,
  parameter int     GLITCH_CYCLES = 10
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_enable,
  input  logic                     i_e_in,
  output logic                     o_sweep_valid,
  output logic [COUNTER_WIDTH-1:0] o_sweep_duration,
  output logic                     o_sweep_axis,
  output logic                     o_sweep_lighthouse,
  output logic                     o_ootx_valid,
  output logic                     o_ootx_data,
  output logic                     o_ootx_lighthouse,
  output logic                     o_pulse_error
);

  localparam int SYNC_BASE = sync_base(CLK_SPEED);
  localparam int SYNC_STEP = sync_step(CLK_SPEED);
  localparam int SYNC_HALF = sync_half(CLK_SPEED);
  localparam int SWEEP_MAX = sweep_max(CLK_SPEED);
  localparam logic [COUNTER_WIDTH-1:0] SYNC_MIN_W = COUNTER_WIDTH'(SYNC_BASE - SYNC_HALF);
  localparam logic [COUNTER_WIDTH-1:0] SYNC_MAX_W = COUNTER_WIDTH'(SYNC_BASE + 7*SYNC_STEP + SYNC_HALF);
  localparam logic [COUNTER_WIDTH-1:0] LONG_MAX_W = COUNTER_WIDTH'(SYNC_BASE + 7*SYNC_STEP + SYNC_HALF + 1);
  localparam logic [COUNTER_WIDTH-1:0] LH_GAP_W   = COUNTER_WIDTH'(lh_gap(CLK_SPEED));
  localparam logic [COUNTER_WIDTH-1:0] WINDOW_W   = COUNTER_WIDTH'(sweep_window(CLK_SPEED));

  logic [COUNTER_WIDTH-1:0] r_width;
  logic                     w_drop;

`ifdef DECODER_GLITCH_FILTER_EN
  localparam int SWEEP_LIMIT = SWEEP_MAX;
  assign w_drop = (r_width < COUNTER_WIDTH'(GLITCH_CYCLES));
`else
  // glitches fall into the sweep class even if configured wider than a sweep
  localparam int SWEEP_LIMIT = (GLITCH_CYCLES > SWEEP_MAX) ? GLITCH_CYCLES : SWEEP_MAX;
  assign w_drop = 1'b0;
`endif

  state_t                   r_state;
  logic [COUNTER_WIDTH-1:0] r_counter, r_rise_ts, r_ref_ts, r_prev_ts, r_duration;
  logic                     r_ref_valid, r_ref_axis, r_ref_lh, r_prev_sync;
  logic                     r_sweep_valid, r_sweep_axis, r_sweep_lh;
  logic                     r_ootx_valid, r_ootx_data, r_ootx_lh, r_pulse_error;

  logic                     w_level, w_rise, w_fall;
  logic [COUNTER_WIDTH-1:0] w_width_inc, w_delta;
  logic [2:0]               w_code;
  logic                     w_is_sync, w_is_sweep, w_lh, w_age_out, w_ref_live;

  lighthouse_edge_sync u_edge (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_d    (i_e_in),
    .o_level(w_level),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  always_comb begin
    w_code = 3'd7;
    for (int n = 6; n >= 0; n--) begin
      if (r_width < COUNTER_WIDTH'(SYNC_BASE + n*SYNC_STEP + SYNC_HALF)) w_code = 3'(n);
    end
  end

  assign w_width_inc = r_width + 1'b1;
  assign w_delta     = r_rise_ts - r_ref_ts;
  assign w_is_sync   = (r_width >= SYNC_MIN_W) && (r_width <= SYNC_MAX_W);
  assign w_is_sweep  = (r_width < COUNTER_WIDTH'(SWEEP_LIMIT));
  assign w_lh        = r_prev_sync && ((r_rise_ts - r_prev_ts) < LH_GAP_W);
  assign w_age_out   = r_ref_valid && ((r_counter - r_ref_ts) >= WINDOW_W);
  assign w_ref_live  = r_ref_valid && !w_age_out;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_counter     <= '0;
      r_rise_ts     <= '0;
      r_width       <= '0;
      r_ref_ts      <= '0;
      r_prev_ts     <= '0;
      r_duration    <= '0;
      r_ref_valid   <= 1'b0;
      r_ref_axis    <= 1'b0;
      r_ref_lh      <= 1'b0;
      r_prev_sync   <= 1'b0;
      r_sweep_valid <= 1'b0;
      r_sweep_axis  <= 1'b0;
      r_sweep_lh    <= 1'b0;
      r_ootx_valid  <= 1'b0;
      r_ootx_data   <= 1'b0;
      r_ootx_lh     <= 1'b0;
      r_pulse_error <= 1'b0;
    end else begin
      r_counter     <= r_counter + 1'b1;
      r_sweep_valid <= 1'b0;
      r_ootx_valid  <= 1'b0;
      r_pulse_error <= 1'b0;
      if (w_age_out) r_ref_valid <= 1'b0;

      if (!i_enable) begin
        r_state     <= ST_IDLE;
        r_ref_valid <= 1'b0;
        r_prev_sync <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE:      r_state <= ST_WAIT_LOW;
          ST_WAIT_LOW:  if (!w_level) r_state <= ST_WAIT_RISE;
          ST_WAIT_RISE: if (w_rise) begin
            r_rise_ts <= r_counter;
            r_width   <= '0;
            r_state   <= ST_MEASURE;
          end
          ST_MEASURE: begin
            r_width <= w_width_inc;
            if (w_fall) begin
              r_state <= ST_CLASSIFY;
            end else if (w_width_inc == LONG_MAX_W) begin
              r_pulse_error <= 1'b1;
              r_state       <= ST_WAIT_LOW;
            end
          end
          ST_CLASSIFY: begin
            r_state <= ST_WAIT_RISE;
            if (!w_drop) begin
              r_prev_sync <= w_is_sync;
              r_prev_ts   <= r_rise_ts;
              if (w_is_sync) begin
                r_ootx_valid <= 1'b1;
                r_ootx_data  <= w_code[CODE_DATA];
                r_ootx_lh    <= w_lh;
                if (!w_code[CODE_SKIP]) begin
                  r_ref_ts    <= r_rise_ts;
                  r_ref_axis  <= w_code[CODE_AXIS];
                  r_ref_lh    <= w_lh;
                  r_ref_valid <= 1'b1;
                end
              end else if (w_is_sweep) begin
                if (w_ref_live && (w_delta < WINDOW_W)) begin
                  r_sweep_valid <= 1'b1;
                  r_duration    <= w_delta + (r_width >> 1);
                  r_sweep_axis  <= r_ref_axis;
                  r_sweep_lh    <= r_ref_lh;
                  r_ref_valid   <= 1'b0;
                end
              end else begin
                r_pulse_error <= 1'b1;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_sweep_valid      = r_sweep_valid;
  assign o_sweep_duration   = r_duration;
  assign o_sweep_axis       = r_sweep_axis;
  assign o_sweep_lighthouse = r_sweep_lh;
  assign o_ootx_valid       = r_ootx_valid;
  assign o_ootx_data        = r_ootx_data;
  assign o_ootx_lighthouse  = r_ootx_lh;
  assign o_pulse_error      = r_pulse_error;

endmodule

// File: tb/tb_lighthouse_pulse_decoder.sv
// tb/tb_lighthouse_pulse_decoder.sv - scoreboard bench at CLK_SPEED 2.5 MHz; honours DECODER_GLITCH_FILTER_EN
module tb_lighthouse_pulse_decoder;

  // 2.5 MHz: code bins <169,195,221,247,273,299,325,351; sync 143..351;
  // long error at 352; sweep <75; group gap 2500; sweep window 20833
  localparam int CW = 20;
  localparam logic [1:0] K_OOTX  = 2'd0;
  localparam logic [1:0] K_SWEEP = 2'd1;
  localparam logic [1:0] K_ERR   = 2'd2;

  typedef struct packed {
    logic [1:0]    kind;
    logic          data;
    logic          lh;
    logic          axis;
    logic [CW-1:0] dur;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, enable, e_in;
  logic          o_sweep_valid, o_sweep_axis, o_sweep_lighthouse;
  logic [CW-1:0] o_sweep_duration;
  logic          o_ootx_valid, o_ootx_data, o_ootx_lighthouse, o_pulse_error;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  lighthouse_pulse_decoder #(
    .CLK_SPEED    (2_500_000),
    .COUNTER_WIDTH(CW),
    .GLITCH_CYCLES(10)
  ) u_dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_enable          (enable),
    .i_e_in            (e_in),
    .o_sweep_valid     (o_sweep_valid),
    .o_sweep_duration  (o_sweep_duration),
    .o_sweep_axis      (o_sweep_axis),
    .o_sweep_lighthouse(o_sweep_lighthouse),
    .o_ootx_valid      (o_ootx_valid),
    .o_ootx_data       (o_ootx_data),
    .o_ootx_lighthouse (o_ootx_lighthouse),
    .o_pulse_error     (o_pulse_error)
  );

  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  task automatic push_ootx(input logic d, input logic lh);
    exp_q.push_back('{kind: K_OOTX, data: d, lh: lh, axis: 1'b0, dur: '0});
  endtask

  task automatic push_sweep(input int dur, input logic axis, input logic lh);
    exp_q.push_back('{kind: K_SWEEP, data: 1'b0, lh: lh, axis: axis, dur: CW'(dur)});
  endtask

  task automatic push_err();
    exp_q.push_back('{kind: K_ERR, data: 1'b0, lh: 1'b0, axis: 1'b0, dur: '0});
  endtask

  // called at posedge+1; leaves e_in high for hi cycles, returns period cycles later
  task automatic pulse(input int hi, input int period);
    e_in = 1'b1;
    repeat (hi) @(posedge clk);
    #1 e_in = 1'b0;
    repeat (period - hi) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && o_ootx_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL ootx_unexpected data=%0d lh=%0d required=no strobe", o_ootx_data, o_ootx_lighthouse);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.kind != K_OOTX || mon_e.data != o_ootx_data || mon_e.lh != o_ootx_lighthouse) begin
          failures++;
          $display("FAIL ootx got kind=0 data=%0d lh=%0d required kind=%0d data=%0d lh=%0d",
                   o_ootx_data, o_ootx_lighthouse, mon_e.kind, mon_e.data, mon_e.lh);
        end
      end
    end
    if (!rst && o_sweep_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sweep_unexpected dur=%0d required=no strobe", o_sweep_duration);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.kind != K_SWEEP || mon_e.dur != o_sweep_duration ||
            mon_e.axis != o_sweep_axis || mon_e.lh != o_sweep_lighthouse) begin
          failures++;
          $display("FAIL sweep got kind=1 dur=%0d axis=%0d lh=%0d required kind=%0d dur=%0d axis=%0d lh=%0d",
                   o_sweep_duration, o_sweep_axis, o_sweep_lighthouse,
                   mon_e.kind, mon_e.dur, mon_e.axis, mon_e.lh);
        end
      end
    end
    if (!rst && o_pulse_error) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL error_unexpected got=1 required=no strobe");
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.kind != K_ERR) begin
          failures++;
          $display("FAIL error got kind=2 required kind=%0d", mon_e.kind);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; e_in = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_sweep_valid", int'(o_sweep_valid), 0);
    chk("rst_sweep_duration", int'(o_sweep_duration), 0);
    chk("rst_sweep_axis", int'(o_sweep_axis), 0);
    chk("rst_sweep_lh", int'(o_sweep_lighthouse), 0);
    chk("rst_ootx_valid", int'(o_ootx_valid), 0);
    chk("rst_ootx_data", int'(o_ootx_data), 0);
    chk("rst_ootx_lh", int'(o_ootx_lighthouse), 0);
    chk("rst_pulse_error", int'(o_pulse_error), 0);
    @(posedge clk); #1 enable = 1'b1;
    repeat (10) @(posedge clk); #1;

    // code 0 sync, sweep 5000 later
    push_ootx(1'b0, 1'b0);          pulse(156, 5000);
    push_sweep(5010, 1'b0, 1'b0);   pulse(20, 1000);

    // skip sync (code 4) then axis-1 data-1 sync (code 3) as second of group
    push_ootx(1'b0, 1'b0);          pulse(260, 1000);
    push_ootx(1'b1, 1'b1);          pulse(234, 7500);
    push_sweep(7506, 1'b1, 1'b1);   pulse(12, 1000);

    // sweep without reference, then a sweep past the window: both dropped
    pulse(30, 1000);
    push_ootx(1'b0, 1'b0);          pulse(156, 21000);
    pulse(20, 1000);

    // over-long pulse, then code 1 sync, mid-band error, sweep still uses reference
    push_err();                     pulse(400, 3000);
    push_ootx(1'b0, 1'b0);          pulse(180, 2500);
    push_err();                     pulse(100, 500);
    push_sweep(3015, 1'b1, 1'b0);   pulse(30, 1000);

    // class boundaries
    push_err();                     pulse(142, 1000);
    push_ootx(1'b0, 1'b0);          pulse(143, 1000);
    push_sweep(1037, 1'b0, 1'b0);   pulse(74, 1000);
    push_err();                     pulse(75, 1000);
    push_ootx(1'b1, 1'b0);          pulse(351, 3000);

    // enable dropped mid-pulse and re-raised with E high
    push_ootx(1'b0, 1'b0);          pulse(156, 1000);
    e_in = 1'b1;
    repeat (100) @(posedge clk); #1 enable = 1'b0;
    repeat (20)  @(posedge clk); #1 enable = 1'b1;
    repeat (200) @(posedge clk); #1 e_in = 1'b0;
    repeat (1000) @(posedge clk); #1;
    pulse(20, 1000);
    push_ootx(1'b1, 1'b0);          pulse(200, 1500);
    push_sweep(1520, 1'b0, 1'b0);   pulse(40, 1000);

    // 5-cycle glitch between sync and sweep
    push_ootx(1'b0, 1'b0);          pulse(156, 400);
`ifdef DECODER_GLITCH_FILTER_EN
    pulse(5, 2000);
    push_sweep(2410, 1'b0, 1'b0);   pulse(20, 1000);
`else
    push_sweep(402, 1'b0, 1'b0);    pulse(5, 2000);
    pulse(20, 1000);
`endif

    repeat (200) @(posedge clk);
    @(negedge clk);
    chk("drain_pending", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lighthouse_pulse_decoder.md
Name: lighthouse_pulse_decoder

Overview:
- Downstream consumer of the TS4231 configuration stage: one instance per sensor, fed by that sensor's envelope (E) line once the sensor reports WATCH state.
- Synchronizes the envelope, measures pulse widths, and classifies each pulse as a Lighthouse v1 sync (OOTX/axis/skip code) or a sweep.
- Emits one-cycle strobes carrying sweep duration (sync rise to sweep centre) and OOTX data bits for the downstream pose/OOTX logic.

Parameters:
- CLK_SPEED, 50_000_000, clock frequency in Hz; all timing thresholds are derived from it.
- COUNTER_WIDTH, 20, width of the timestamp counter and sweep_duration; must cover SWEEP_WINDOW (416_667 cycles at 50 MHz).
- GLITCH_CYCLES, 10, minimum accepted pulse width in cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  high while the sensor is in WATCH state (sensor_STATE==3'b001); low forces IDLE
- E_in  in  1  raw envelope line, asynchronous
- sweep_valid  out  1  one-cycle strobe: sweep measured
- sweep_duration  out  COUNTER_WIDTH  cycles from reference sync rise to sweep centre
- sweep_axis  out  1  axis bit of the reference sync
- sweep_lighthouse  out  1  0 = first sync of group, 1 = second
- ootx_valid  out  1  one-cycle strobe per decoded sync
- ootx_data  out  1  data bit of that sync
- ootx_lighthouse  out  1  lighthouse index of that sync
- pulse_error  out  1  one-cycle strobe: pulse width out of every class

Behaviour:
- Reset: all outputs 0; state IDLE; reference invalid; timestamp counter 0.
- E_in passes through a 2-flop synchronizer, then a registered edge detector.
- Free-running timestamp counter wraps modulo 2^COUNTER_WIDTH; all differences are modular.
- States:
  - IDLE: wait for enable. Enter WAIT_LOW.
  - WAIT_LOW: wait until synchronized E = 0. Enter WAIT_RISE.
  - WAIT_RISE: on rise, latch rise_ts, clear width. Enter MEASURE.
  - MEASURE: width increments each cycle. On fall, enter CLASSIFY. If width reaches LONG_MAX (7033 cycles at 50 MHz), strobe pulse_error and enter WAIT_LOW.
  - CLASSIFY: one cycle; decide and strobe. Enter WAIT_RISE.
- enable low in any state: IDLE next cycle; reference invalidated; no strobes.
- Output latency: strobes assert in the cycle after CLASSIFY. Every output strobe is exactly one cycle wide.
- Thresholds at 50 MHz; each scales linearly with CLK_SPEED:
  - SYNC_BASE = 3125 (62.5 us); SYNC_STEP = 521 (10.42 us).
  - Sync window: 2865 ≤ width ≤ 7032.
  - Sweep: width < 1500 (30 us).
- Sync handling:
  - code n = smallest n (0..7) with width < SYNC_BASE + n*SYNC_STEP + 260.
  - Code bits: bit2 skip, bit1 data, bit0 axis.
  - ootx_valid=1, ootx_data=bit1.
  - lighthouse = 1 if the previous classified pulse was a sync whose rise was < 1000 us earlier, else 0; drives ootx_lighthouse.
  - If skip=0: reference_ts = rise_ts, ref_axis, ref_lh latched, reference valid.
- Sweep handling:
  - If reference is valid and (rise_ts − reference_ts) < SWEEP_WINDOW (8.333 ms): sweep_valid=1 and sweep_duration = rise_ts − reference_ts + width>>1 (truncated); reference invalidated.
  - Otherwise the sweep is dropped silently.
- Width 1500..2864: pulse_error; reference unchanged.
- Reference ages out when the counter passes reference_ts + SWEEP_WINDOW.
- A sweep and an age-out in the same cycle: age-out wins.

Optional Feature:
- DECODER_GLITCH_FILTER_EN defined: pulses with width < GLITCH_CYCLES are discarded in CLASSIFY. No strobe; the previous-pulse history used for lighthouse indexing is unchanged.
- Not defined: such pulses are classified as sweeps.

Decomposition:
- Package lighthouse_pkg holds:
  - state encoding;
  - sync-code bit positions (SKIP=2, DATA=1, AXIS=0);
  - threshold functions of CLK_SPEED.
- Sub-module lighthouse_edge_sync: 2-flop synchronizer plus rise/fall detector, reusable by future D-line logic.

Test Plan:
- Sync, code 0, width 3125; sweep rise 100_000 cycles after sync rise, width 200 -> ootx_valid with data 0; sweep_valid with duration 100_100, axis 0, lighthouse 0.
- Sync code 4 (width 5209), then sync code 3 (width 4688) rising 20_000 cycles later, then sweep at +150_000 (width 100) -> two ootx_valid (data 0, lh 0; data 1, lh 1); sweep duration 150_050, axis 1, lighthouse 1.
- Sweep with no prior sync, and a sweep 420_000 cycles after a valid sync -> no sweep_valid in either case.
- Pulse held high for 8000 cycles -> single pulse_error at width 7033; no other strobe; the next valid sync decodes normally.
- enable dropped mid-MEASURE, then re-raised while E_in is high -> no strobe until E_in falls and a fresh pulse completes.
- 5-cycle glitch between sync and sweep -> with the macro, the following sweep is still reported; without it, the glitch consumes the reference with duration ≈ glitch offset.
